windowed_reg_file: RTL
======================

Name: windowed_reg_file

Overview:
- Parametrised SPARC-style windowed integer register file. Successor to the fixed 32-bit register window.
- Adds a current-window pointer (CWP), a window-invalid mask (WIM), SAVE/RESTORE window rotation and window overflow/underflow trap generation.
- Sits in the integer datapath and feeds operand buses Aout/Bout to the ALU. Receives writeback from the pipeline's final stage.

Parameters:
- WIDTH, 32, data width of every register.
- NWINDOWS, 8, number of register windows (2..32).
- CWPW, 3, width of CWP; must equal ceil(log2(NWINDOWS)).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- RA  input  5  read address, port A (window-relative r0..r31).
- RB  input  5  read address, port B.
- Aout  output  WIDTH  combinational read data, port A.
- Bout  output  WIDTH  combinational read data, port B.
- WA  input  5  write address (window-relative).
- in  input  WIDTH  write data.
- WE  input  1  write enable.
- SAVE  input  1  request: CWP <- (CWP-1) mod NWINDOWS.
- RESTORE  input  1  request: CWP <- (CWP+1) mod NWINDOWS.
- CWP_WE  input  1  direct CWP load enable.
- CWP_IN  input  CWPW  direct CWP load value.
- WIM_WE  input  1  WIM load enable.
- WIM_IN  input  NWINDOWS  WIM load value.
- CWP  output  CWPW  current window pointer.
- WIM  output  NWINDOWS  window-invalid mask.
- WOF  output  1  window overflow trap, one-cycle pulse.
- WUF  output  1  window underflow trap, one-cycle pulse.

Behaviour:
- Physical storage:
  - 8 globals plus NWINDOWS*16 windowed registers.
  - r0..r7 are globals; r8..r15 outs, r16..r23 locals, r24..r31 ins of window CWP.
  - Ins of window w are physically the outs of window (w+1) mod NWINDOWS. Overlap must be exact: a value written to r8 in window w reads back as r24 in window w-1.
- r0 always reads 0. Writes to r0 are discarded.
- Reads:
  - Combinational, using the current CWP register value.
  - No write bypass: a write at edge k becomes visible on Aout/Bout after edge k.
- Writes:
  - Occur at the rising edge when WE=1.
  - Address decode uses the CWP value before that edge, even when SAVE/RESTORE/CWP_WE update CWP in the same cycle.
- CWP update at the rising edge, in priority order:
  1. CWP_WE=1: CWP <- CWP_IN, only if CWP_IN < NWINDOWS; an out-of-range value is ignored and CWP holds. SAVE/RESTORE are ignored that cycle.
  2. SAVE=1 and RESTORE=1 together: illegal. CWP holds, no trap.
  3. SAVE=1: target t=(CWP-1) mod NWINDOWS.
     - If WIM[t]=1: CWP holds and WOF=1 for the next cycle.
     - Else: CWP <- t.
  4. RESTORE=1: target t=(CWP+1) mod NWINDOWS.
     - If WIM[t]=1: CWP holds and WUF=1 for the next cycle.
     - Else: CWP <- t.
- Wrap-around: SAVE from CWP=0 targets NWINDOWS-1; RESTORE from NWINDOWS-1 targets 0.
- WIM:
  - Loaded at the edge when WIM_WE=1.
  - A SAVE/RESTORE in the same cycle is checked against the old WIM.
- WOF/WUF:
  - Registered and high for exactly one cycle per trapping request.
  - Held SAVE produces a WOF pulse every cycle while it traps.
- Reset (Rst_n=0, asynchronous, takes effect immediately):
  - CWP=0; WIM=1<<1 (window 1 invalid); WOF=0; WUF=0.
  - All physical registers cleared to 0.
- Reset mid-operation:
  - Any in-progress SAVE/RESTORE/write is discarded.
  - Normal operation resumes at the first rising edge after Rst_n deasserts.

Test Plan:
- Reset, then RA=8, RB=31 -> Aout=0, Bout=0, CWP=0, WIM=8'h02, WOF=WUF=0.
- CWP=0: write r8=32'h00001111, then SAVE (WIM=8'h02) -> CWP=7; RA=24 reads 32'h00001111; r8 of window 7 reads 0.
- Write r3=32'hCAFEF00D in window 0, then SAVE twice -> r3 reads 32'hCAFEF00D in every window. Write r0=32'hFFFFFFFF -> r0 still reads 0.
- CWP=0, WIM=8'h02, RESTORE -> WUF pulses one cycle, CWP stays 0. Load WIM=8'h40, SAVE from 0 to 7, then SAVE -> WOF pulses, CWP stays 7.
- Simultaneous cases:
  - WE=1, WA=16, in=32'h12345678 with SAVE at CWP=0 -> value lands in window 0 locals; visible again after RESTORE.
  - SAVE+RESTORE together -> CWP unchanged, no trap.
  - CWP_WE with CWP_IN=5 plus SAVE -> CWP=5.
- CWP_WE with CWP_IN=3 loads CWP=3. With NWINDOWS=6 (CWPW=3), CWP_IN=7 -> CWP unchanged. Assert Rst_n=0 mid-cycle while SAVE is high -> CWP=0 immediately, WOF stays 0.

Source files
------------

// File: rtl/windowed_reg_file_if.sv
// Bus interface for windowed_reg_file.
// Carries the operand read ports (RA/RB -> Aout/Bout), the writeback port
// (WA/in/WE), the window-control requests (SAVE/RESTORE/CWP_WE/CWP_IN,
// WIM_WE/WIM_IN) and the window status outputs (CWP, WIM, WOF, WUF).
// master: the pipeline side driving requests; slave: the register file.
interface windowed_reg_file_if #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8,
  parameter int CWPW     = 3
);
  logic [4:0]          RA;
  logic [4:0]          RB;
  logic [WIDTH-1:0]    Aout;
  logic [WIDTH-1:0]    Bout;
  logic [4:0]          WA;
  logic [WIDTH-1:0]    in;
  logic                WE;
  logic                SAVE;
  logic                RESTORE;
  logic                CWP_WE;
  logic [CWPW-1:0]     CWP_IN;
  logic                WIM_WE;
  logic [NWINDOWS-1:0] WIM_IN;
  logic [CWPW-1:0]     CWP;
  logic [NWINDOWS-1:0] WIM;
  logic                WOF;
  logic                WUF;

  modport master (
    output RA, RB, WA, in, WE, SAVE, RESTORE, CWP_WE, CWP_IN, WIM_WE, WIM_IN,
    input  Aout, Bout, CWP, WIM, WOF, WUF
  );

  modport slave (
    input  RA, RB, WA, in, WE, SAVE, RESTORE, CWP_WE, CWP_IN, WIM_WE, WIM_IN,
    output Aout, Bout, CWP, WIM, WOF, WUF
  );
endinterface

// File: rtl/windowed_reg_file.sv
// SPARC-style windowed integer register file.
// Storage: 8 globals (r0 hardwired to zero) plus NWINDOWS*16 windowed
// registers. Window w owns 16 physical slots: outs (r8..r15) at offset 0..7
// and locals (r16..r23) at offset 8..15. Its ins (r24..r31) alias the outs of
// window (w+1) mod NWINDOWS, so overlap is exact by construction.
// Ports:
//   Clk   - rising-edge clock
//   Rst_n - asynchronous active-low reset (clears CWP, WIM=1<<1, traps, data)
//   bus   - slave side of windowed_reg_file_if:
//           RA/RB -> Aout/Bout combinational reads at the current CWP,
//           WA/in/WE writeback, SAVE/RESTORE window rotation,
//           CWP_WE/CWP_IN direct CWP load, WIM_WE/WIM_IN mask load,
//           CWP/WIM status, WOF/WUF one-cycle trap pulses.
module windowed_reg_file #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8,
  parameter int CWPW     = 3
) (
  input  logic                Clk,
  input  logic                Rst_n,
  windowed_reg_file_if.slave  bus
);

  localparam int unsigned NPHYS = NWINDOWS * 16;
  localparam int unsigned IDXW  = $clog2(NPHYS);
  localparam logic [NWINDOWS-1:0] WIM_RST = NWINDOWS'(2);
  localparam logic [CWPW-1:0]     CWP_MAX = CWPW'(NWINDOWS - 1);

  logic [WIDTH-1:0]    glb [8];
  logic [WIDTH-1:0]    win [NPHYS];

  logic [CWPW-1:0]     cwp;
  logic [CWPW-1:0]     cwp_next;
  logic [CWPW-1:0]     save_tgt;
  logic [CWPW-1:0]     rest_tgt;
  logic [NWINDOWS-1:0] wim;
  logic                wof;
  logic                wuf;
  logic                wof_next;
  logic                wuf_next;

  logic [IDXW-1:0]     a_idx;
  logic [IDXW-1:0]     b_idx;
  logic [IDXW-1:0]     w_idx;
  logic [WIDTH-1:0]    aout;
  logic [WIDTH-1:0]    bout;

  // Physical slot of a windowed register (r8..r31) seen from window w.
  function automatic logic [IDXW-1:0] win_idx(input logic [CWPW-1:0] w,
                                               input logic [4:0]      r);
    int unsigned w_phys;
    logic [3:0]  off;
    if (r[4:3] == 2'b11)
      w_phys = (w == CWP_MAX) ? 0 : int'(w) + 1;
    else
      w_phys = int'(w);
    // locals sit above the outs; outs and ins both use offset 0..7
    off = {r[4:3] == 2'b10, r[2:0]};
    return IDXW'(w_phys * 16 + {28'd0, off});
  endfunction

  // Combinational reads at the current CWP; no bypass of the pending write.
  always_comb begin
    a_idx = win_idx(cwp, bus.RA);
    b_idx = win_idx(cwp, bus.RB);
    w_idx = win_idx(cwp, bus.WA);
    aout  = '0;
    bout  = '0;
    if (bus.RA != 5'd0)
      aout = (bus.RA[4:3] == 2'b00) ? glb[bus.RA[2:0]] : win[a_idx];
    if (bus.RB != 5'd0)
      bout = (bus.RB[4:3] == 2'b00) ? glb[bus.RB[2:0]] : win[b_idx];
  end

  assign bus.Aout = aout;
  assign bus.Bout = bout;

  // Write decode uses the pre-edge CWP, so a concurrent SAVE/RESTORE/load
  // never redirects the write into the new window.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < 8; i++) glb[i] <= '0;
      for (int unsigned i = 0; i < NPHYS; i++) win[i] <= '0;
    end else if (bus.WE && bus.WA != 5'd0) begin
      if (bus.WA[4:3] == 2'b00) glb[bus.WA[2:0]] <= bus.in;
      else                      win[w_idx]       <= bus.in;
    end
  end

  // Window control: direct load beats rotation; SAVE+RESTORE together is a
  // no-op; a rotation into an invalid window holds CWP and raises a trap.
  always_comb begin
    save_tgt = (cwp == '0) ? CWP_MAX : cwp - CWPW'(1);
    rest_tgt = (cwp == CWP_MAX) ? '0 : cwp + CWPW'(1);
    cwp_next = cwp;
    wof_next = 1'b0;
    wuf_next = 1'b0;
    if (bus.CWP_WE) begin
      if (int'(bus.CWP_IN) < NWINDOWS) cwp_next = bus.CWP_IN;
    end else if (bus.SAVE && bus.RESTORE) begin
      cwp_next = cwp;
    end else if (bus.SAVE) begin
      if (wim[save_tgt]) wof_next = 1'b1;
      else               cwp_next = save_tgt;
    end else if (bus.RESTORE) begin
      if (wim[rest_tgt]) wuf_next = 1'b1;
      else               cwp_next = rest_tgt;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cwp <= '0;
      wim <= WIM_RST;
      wof <= 1'b0;
      wuf <= 1'b0;
    end else begin
      cwp <= cwp_next;
      wof <= wof_next;
      wuf <= wuf_next;
      if (bus.WIM_WE) wim <= bus.WIM_IN;
    end
  end

  assign bus.CWP = cwp;
  assign bus.WIM = wim;
  assign bus.WOF = wof;
  assign bus.WUF = wuf;

endmodule
